door_controller: RTL and testbench
==================================

DOOR_CONTROLLER -- requirements
Module: door_controller

Interface
REQ-001 SHALL have parameter MOVE_CYCLES, default 8, meaning door travel time in clk cycles (legal 1..255).
REQ-002 SHALL have parameter HOLD_CYCLES, default 20, meaning open dwell time in clk cycles (legal 1..255).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port arrived  input  1  one-cycle pulse: cabin has stopped at a floor.
REQ-006 SHALL have port open_btn  input  1  level: door-open request.
REQ-007 SHALL have port close_btn  input  1  level: door-close request.
REQ-008 SHALL have port door_obstructed  input  1  level: obstruction sensor.
REQ-009 SHALL have port weight_limit_exceeded  input  1  level: cabin overload flag from the weight stage.
REQ-010 SHALL have port door  output  1  high whenever the door is not fully closed; drives the weight stage's door input.
REQ-011 SHALL have port door_closed  output  1  high only in CLOSED; cabin may move.
REQ-012 SHALL have port weight_flip_reset  output  1  one-cycle pulse that clears the weight stage's passenger count.
REQ-013 SHALL have port overweight_alarm  output  1  buzzer: overload while door open.

Function
REQ-014 SHALL implement FSM states CLOSED, OPENING, OPEN, CLOSING, plus an 8-bit down-counter timer.
REQ-015 CLOSED: arrived or open_btn -> OPENING, timer loaded MOVE_CYCLES-1; otherwise hold.
REQ-016 OPENING: timer decrements each cycle; at timer==0 -> OPEN, timer loaded HOLD_CYCLES-1.
REQ-017 OPEN: open_btn, door_obstructed or weight_limit_exceeded reloads timer to HOLD_CYCLES-1 and stays OPEN.
REQ-018 OPEN, none of REQ-017 active: close_btn -> CLOSING immediately; else decrement, and at timer==0 -> CLOSING.
REQ-019 Entering CLOSING SHALL load timer MOVE_CYCLES-1.
REQ-020 CLOSING: open_btn, door_obstructed or weight_limit_exceeded -> OPENING, timer loaded MOVE_CYCLES-1 (full reversal).
REQ-021 CLOSING, no reversal cause: decrement; at timer==0 -> CLOSED.
REQ-022 Priority, highest first: reset, reversal/hold causes (REQ-017/020), close_btn, timer expiry.
REQ-023 arrived SHALL be ignored in every state except CLOSED.
REQ-024 weight_flip_reset SHALL pulse high exactly one cycle, in the cycle after a CLOSED->OPENING transition caused by arrived; not on open_btn-only reopen.
REQ-025 door SHALL be registered, equal 1 in OPENING, OPEN, CLOSING, and change one cycle after the state change.
REQ-026 door_closed SHALL be registered, equal to NOT door.
REQ-027 overweight_alarm SHALL be registered, equal weight_limit_exceeded AND (state != CLOSED), one-cycle latency.
REQ-028 Timer SHALL never underflow; decrement occurs only when timer > 0.

Reset
REQ-029 reset_n low SHALL asynchronously force state CLOSED, timer 0, door 0, door_closed 1, weight_flip_reset 0, overweight_alarm 0.
REQ-030 Reset asserted mid-motion SHALL abort immediately; after release the FSM waits in CLOSED for a new request.
REQ-031 Reset release SHALL take effect on the next rising clk edge; no outputs glitch during release.

Structure
REQ-032 State encoding and default MOVE_CYCLES/HOLD_CYCLES constants SHALL reside in shared package elevator_pkg.
REQ-033 Timer SHALL be one sub-module door_timer (load value, load strobe, decrement, zero flag).
REQ-034 Total RTL SHALL be single-clock with no combinational path from inputs to outputs.

Verification
REQ-035 Arrival cycle: arrived pulse at cycle 0, no other inputs -> weight_flip_reset at cycle 1, door=1 at cycle 1, OPEN after 8 cycles, CLOSING after 20 more, door_closed=1 after 8 more.
REQ-036 Overload hold: weight_limit_exceeded=1 throughout OPEN for 50 cycles -> door stays 1, overweight_alarm=1; deassert -> closes 20+8 cycles later.
REQ-037 Reversal: door_obstructed pulse on 4th cycle of CLOSING -> OPENING next cycle, full 8-cycle reopen, no weight_flip_reset pulse.
REQ-038 Simultaneous close_btn and door_obstructed in OPEN -> stays OPEN, timer reloaded to 19.
REQ-039 reset_n low on 3rd cycle of OPENING -> door=0, door_closed=1 asynchronously; arrived during CLOSED after release reopens normally.
REQ-040 arrived pulse while OPEN -> no state change, no weight_flip_reset pulse.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator door path.
//   - Door FSM state encoding (2-bit, legacy-compatible localparams).
//   - Default door travel / dwell times in clk cycles.
//   - Timer width.
package elevator_pkg;

  localparam int unsigned TIMER_W = 8;

  localparam logic [1:0] ST_CLOSED  = 2'd0;
  localparam logic [1:0] ST_OPENING = 2'd1;
  localparam logic [1:0] ST_OPEN    = 2'd2;
  localparam logic [1:0] ST_CLOSING = 2'd3;

  localparam int unsigned DEFAULT_MOVE_CYCLES = 8;
  localparam int unsigned DEFAULT_HOLD_CYCLES = 20;

endpackage

// File: rtl/door_timer.sv
// door_timer: 8-bit down-counter used by the door FSM.
// Ports:
//   clk, reset_n  - clock, async active-low reset (count -> 0)
//   load_val      - value written when load is high
//   load          - load strobe (wins over dec)
//   dec           - decrement request; ignored when count is already 0
//   count         - current timer value
//   zero          - count == 0
module door_timer
  import elevator_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               load,
  input  logic               dec,
  output logic [TIMER_W-1:0] count,
  output logic               zero
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      // Saturate at zero: the counter never wraps.
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/door_controller.sv
// door_controller: elevator cabin door sequencer.
// Parameters:
//   MOVE_CYCLES - door travel time in clk cycles (1..255)
//   HOLD_CYCLES - open dwell time in clk cycles (1..255)
// Ports:
//   clk, reset_n          - clock, async active-low reset
//   arrived               - one-cycle pulse, cabin stopped at a floor
//   open_btn, close_btn   - door request levels
//   door_obstructed       - obstruction sensor level
//   weight_limit_exceeded - overload flag from the weight stage
//   door                  - registered, high when door not fully closed
//   door_closed           - registered, NOT door
//   weight_flip_reset     - one-cycle pulse clearing the passenger count
//   overweight_alarm      - registered buzzer, overload while not closed
//   dbg_state, dbg_timer  - FSM state and timer value for observation
module door_controller
  import elevator_pkg::*;
#(
  parameter int unsigned MOVE_CYCLES = DEFAULT_MOVE_CYCLES,
  parameter int unsigned HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               arrived,
  input  logic               open_btn,
  input  logic               close_btn,
  input  logic               door_obstructed,
  input  logic               weight_limit_exceeded,
  output logic               door,
  output logic               door_closed,
  output logic               weight_flip_reset,
  output logic               overweight_alarm,
  output logic [1:0]         dbg_state,
  output logic [TIMER_W-1:0] dbg_timer
);

  localparam logic [TIMER_W-1:0] MOVE_LOAD = TIMER_W'(MOVE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_CYCLES - 1);

  logic [1:0]         state;
  logic [1:0]         next_state;
  logic               tmr_load;
  logic               tmr_dec;
  logic [TIMER_W-1:0] tmr_load_val;
  logic [TIMER_W-1:0] tmr_count;
  logic               tmr_zero;
  logic               hold_cause;
  logic               arm_next;
  logic               flip_armed;

  // Anything that keeps the door open (or reopens it while closing).
  assign hold_cause = open_btn | door_obstructed | weight_limit_exceeded;

  door_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_val (tmr_load_val),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .count    (tmr_count),
    .zero     (tmr_zero)
  );

  always_comb begin
    next_state   = state;
    tmr_load     = 1'b0;
    tmr_load_val = MOVE_LOAD;
    tmr_dec      = 1'b0;
    arm_next     = 1'b0;
    case (state)
      ST_CLOSED: begin
        if (arrived || open_btn) begin
          next_state = ST_OPENING;
          tmr_load   = 1'b1;
          // Only an arrival starts a new passenger load.
          arm_next   = arrived;
        end
      end
      ST_OPENING: begin
        if (tmr_zero) begin
          next_state   = ST_OPEN;
          tmr_load     = 1'b1;
          tmr_load_val = HOLD_LOAD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_OPEN: begin
        if (hold_cause) begin
          tmr_load     = 1'b1;
          tmr_load_val = HOLD_LOAD;
        end else if (close_btn || tmr_zero) begin
          next_state = ST_CLOSING;
          tmr_load   = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_CLOSING: begin
        if (hold_cause) begin
          next_state = ST_OPENING;
          tmr_load   = 1'b1;
        end else if (tmr_zero) begin
          next_state = ST_CLOSED;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: begin
        next_state = ST_CLOSED;
      end
    endcase
  end

  // Outputs are all registered from the current state, so they trail the
  // state register by one cycle. flip_armed delays the arrival event by the
  // same amount so the pulse lines up with door rising.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= ST_CLOSED;
      flip_armed        <= 1'b0;
      door              <= 1'b0;
      door_closed       <= 1'b1;
      weight_flip_reset <= 1'b0;
      overweight_alarm  <= 1'b0;
    end else begin
      state             <= next_state;
      flip_armed        <= arm_next;
      door              <= (state != ST_CLOSED);
      door_closed       <= (state == ST_CLOSED);
      weight_flip_reset <= flip_armed;
      overweight_alarm  <= weight_limit_exceeded && (state != ST_CLOSED);
    end
  end

  assign dbg_state = state;
  assign dbg_timer = tmr_count;

endmodule

// File: tb/tb_door_controller.sv
// Bench for door_controller: directed scenarios followed by random stimulus,
// checked against a phase/cycles-remaining reference model.
module tb_door_controller;
  import elevator_pkg::*;

  localparam int MOVE = DEFAULT_MOVE_CYCLES;
  localparam int HOLD = DEFAULT_HOLD_CYCLES;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic arrived = 0, open_btn = 0, close_btn = 0;
  logic door_obstructed = 0, weight_limit_exceeded = 0;
  logic door, door_closed, weight_flip_reset, overweight_alarm;
  logic [1:0] dbg_state;
  logic [7:0] dbg_timer;

  door_controller #(.MOVE_CYCLES(MOVE), .HOLD_CYCLES(HOLD)) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .arrived               (arrived),
    .open_btn              (open_btn),
    .close_btn             (close_btn),
    .door_obstructed       (door_obstructed),
    .weight_limit_exceeded (weight_limit_exceeded),
    .door                  (door),
    .door_closed           (door_closed),
    .weight_flip_reset     (weight_flip_reset),
    .overweight_alarm      (overweight_alarm),
    .dbg_state             (dbg_state),
    .dbg_timer             (dbg_timer)
  );

  int total = 0;
  int bad = 0;

  // ---------------- reference model ----------------
  // phase: 0 shut, 1 moving open, 2 dwelling open, 3 moving shut.
  // left: cycles still to spend in the phase, counting the current one.
  int m_phase = 0;
  int m_left = 1;
  bit m_arm = 0;
  logic [3:0] exp_q[$];  // {door, door_closed, weight_flip_reset, overweight_alarm}

  function automatic logic [1:0] phase_code(int p);
    case (p)
      0: return ST_CLOSED;
      1: return ST_OPENING;
      2: return ST_OPEN;
      default: return ST_CLOSING;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_left = 1;
    m_arm = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit holding;
    bit arm_new;
    holding = open_btn || door_obstructed || weight_limit_exceeded;
    arm_new = 0;
    exp_q.push_back({m_phase != 0, m_phase == 0, m_arm,
                     weight_limit_exceeded && (m_phase != 0)});
    case (m_phase)
      0: if (arrived || open_btn) begin
           m_phase = 1; m_left = MOVE; arm_new = arrived;
         end
      1: if (m_left == 1) begin m_phase = 2; m_left = HOLD; end
         else m_left--;
      2: if (holding) m_left = HOLD;
         else if (close_btn || m_left == 1) begin m_phase = 3; m_left = MOVE; end
         else m_left--;
      default: if (holding) begin m_phase = 1; m_left = MOVE; end
               else if (m_left == 1) m_phase = 0;
               else m_left--;
    endcase
    m_arm = arm_new;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(string tag, int got, int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock: model follows the DUT edge, outputs compared on the falling edge.
  task automatic tick();
    logic [3:0] e;
    @(posedge clk);
    model_step();
    @(negedge clk);
    e = exp_q.pop_front();
    chk("outs", int'({door, door_closed, weight_flip_reset, overweight_alarm}), int'(e));
    chk("state", int'(dbg_state), int'(phase_code(m_phase)));
    chk("timer", int'(dbg_timer), m_left - 1);
  endtask

  task automatic clear_inputs();
    arrived = 0; open_btn = 0; close_btn = 0;
    door_obstructed = 0; weight_limit_exceeded = 0;
  endtask

  task automatic wait_state(logic [1:0] code, int budget);
    int n = 0;
    while (dbg_state !== code && n < budget) begin
      tick();
      n++;
    end
    chk("wait_state", int'(dbg_state), int'(code));
  endtask

  // Async reset pulse starting mid-cycle; released on the next falling edge.
  task automatic async_reset();
    #2 reset_n = 0;
    #1;
    model_reset();
    chk("rst_door", int'(door), 0);
    chk("rst_closed", int'(door_closed), 1);
    chk("rst_flip", int'(weight_flip_reset), 0);
    chk("rst_alarm", int'(overweight_alarm), 0);
    chk("rst_state", int'(dbg_state), int'(ST_CLOSED));
    chk("rst_timer", int'(dbg_timer), 0);
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic arrive_and_count(string tag);
    int n;
    arrived = 1;
    tick();
    arrived = 0;
    n = 1;
    while (door_closed && n < 10) begin tick(); n++; end
    while (!door_closed && n < 300) begin tick(); n++; end
    chk(tag, n, 2 * MOVE + HOLD + 2);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int n;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    chk("init_door", int'(door), 0);
    chk("init_closed", int'(door_closed), 1);
    chk("init_state", int'(dbg_state), int'(ST_CLOSED));
    reset_n = 1;

    // Arrival cycle: full open / dwell / close sequence.
    arrive_and_count("arrival_len");

    // Overload hold for 50 cycles, then release.
    arrived = 1; tick(); arrived = 0;
    wait_state(ST_OPEN, 20);
    weight_limit_exceeded = 1;
    for (int i = 0; i < 50; i++) tick();
    chk("ovl_door", int'(door), 1);
    chk("ovl_alarm", int'(overweight_alarm), 1);
    weight_limit_exceeded = 0;
    n = 0;
    while (dbg_state !== ST_CLOSING && n < 100) begin tick(); n++; end
    chk("ovl_release", n, HOLD);
    wait_state(ST_CLOSED, 20);

    // Reversal on the 4th cycle of closing.
    open_btn = 1; tick(); open_btn = 0;
    wait_state(ST_CLOSING, 60);
    for (int i = 0; i < 3; i++) tick();
    door_obstructed = 1; tick(); door_obstructed = 0;
    chk("rev_state", int'(dbg_state), int'(ST_OPENING));
    chk("rev_timer", int'(dbg_timer), MOVE - 1);
    n = 0;
    while (dbg_state !== ST_OPEN && n < 50) begin tick(); n++; end
    chk("rev_open_len", n, MOVE);

    // close_btn together with obstruction while open: stays open, reloaded.
    for (int i = 0; i < 5; i++) tick();
    close_btn = 1; door_obstructed = 1; tick(); clear_inputs();
    chk("both_state", int'(dbg_state), int'(ST_OPEN));
    chk("both_timer", int'(dbg_timer), HOLD - 1);

    // arrived while open has no effect.
    arrived = 1; tick(); arrived = 0;
    chk("arr_open_state", int'(dbg_state), int'(ST_OPEN));
    for (int i = 0; i < 3; i++) tick();
    close_btn = 1; tick(); close_btn = 0;
    chk("close_btn_state", int'(dbg_state), int'(ST_CLOSING));
    wait_state(ST_CLOSED, 20);
    tick();

    // Reset on the 3rd cycle of opening, then a normal arrival.
    arrived = 1; tick(); arrived = 0;
    tick(); tick();
    async_reset();
    tick();
    chk("post_rst_state", int'(dbg_state), int'(ST_CLOSED));
    arrive_and_count("arrival_after_rst");

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      arrived               = ($urandom_range(0, 99) < 8);
      open_btn              = ($urandom_range(0, 99) < 4);
      close_btn             = ($urandom_range(0, 99) < 12);
      door_obstructed       = ($urandom_range(0, 99) < 3);
      weight_limit_exceeded = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 599) == 0) async_reset();
      else tick();
    end
    clear_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
